// File: rtl/cell_truth_table_checker.sv
// Exhaustive truth-table sweeper for N-input single-output combinational cells.
// Holds each input vector for SETTLE_CYCLES and then compares cell_out against a selectable reference.
module cell_truth_table_checker #(
  parameter int N_INPUTS      = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [2:0]          mode,
  input  logic                cell_out,
  output logic [N_INPUTS-1:0] stim,
  output logic                busy,
  output logic                sample_valid,
  output logic [N_INPUTS-1:0] sample_vec,
  output logic                sample_exp,
  output logic                sample_got,
  output logic [N_INPUTS:0]   err_count,
  output logic [N_INPUTS-1:0] first_fail,
  output logic                done,
  output logic                pass,
  output logic                mode_err
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [N_INPUTS-1:0] vec;
  logic [2:0]          mode_q;
  logic                exp_w, mismatch, last_vec;

  // Illegal modes still sweep, but against a constant-0 reference.
  function automatic logic ref_fn(input logic [2:0] m, input logic [N_INPUTS-1:0] v);
    case (m)
      3'd0:    return ~|v;
      3'd1:    return ~&v;
      3'd2:    return &v;
      3'd3:    return |v;
      3'd4:    return ^v;
      3'd5:    return ~^v;
      default: return 1'b0;
    endcase
  endfunction

  assign exp_w    = ref_fn(mode_q, vec);
  assign mismatch = exp_w != cell_out;
  assign last_vec = &vec;
  assign busy     = (state == SETTLE) || (state == SAMPLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = SETTLE;
      SETTLE: begin
        if (abort)         state_nxt = IDLE;
        else if (cnt == '0) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (abort)         state_nxt = IDLE;
        else if (last_vec) state_nxt = DONE;
        else               state_nxt = SETTLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      vec          <= '0;
      mode_q       <= '0;
      stim         <= '0;
      sample_valid <= 1'b0;
      sample_vec   <= '0;
      sample_exp   <= 1'b0;
      sample_got   <= 1'b0;
      err_count    <= '0;
      first_fail   <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      mode_err     <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mode_q     <= mode;
            mode_err   <= mode > 3'd5;
            vec        <= '0;
            stim       <= '0;
            cnt        <= RELOAD;
            err_count  <= '0;
            first_fail <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
          end
        end
        SETTLE: begin
          if (abort)           stim <= '0;
          else if (cnt != '0)  cnt  <= cnt - 1'b1;
        end
        SAMPLE: begin
          // abort beats the compare: nothing is recorded on this edge
          if (abort) begin
            stim <= '0;
          end else begin
            sample_valid <= 1'b1;
            sample_vec   <= vec;
            sample_exp   <= exp_w;
            sample_got   <= cell_out;
            if (mismatch) begin
              err_count <= err_count + 1'b1;
              if (err_count == '0) first_fail <= vec;
            end
            if (last_vec) begin
              done <= 1'b1;
              pass <= !mode_err && (err_count == '0) && !mismatch;
              stim <= '0;
            end else begin
              vec  <= vec + 1'b1;
              stim <= vec + 1'b1;
              cnt  <= RELOAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_truth_table_checker.sv
// Directed bench: a 3-input/settle-2 and a 4-input/settle-1 checker, each driven by a truth-table cell model.
module tb_cell_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       sel = 1'b0;
  logic [2:0] mode = '0;
  logic [7:0]  tbl3 = 8'h01;
  logic [15:0] tbl4 = 16'h0000;

  logic [2:0] stim3, svec3, ff3;
  logic [3:0] err3;
  logic       cell3, busy3, sv3, sexp3, sgot3, done3, pass3, merr3;
  logic [3:0] stim4, svec4, ff4;
  logic [4:0] err4;
  logic       cell4, busy4, sv4, sexp4, sgot4, done4, pass4, merr4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign cell3 = tbl3[stim3];
  assign cell4 = tbl4[stim4];

  cell_truth_table_checker #(.N_INPUTS(3), .SETTLE_CYCLES(2)) u3 (
    .clk(clk), .rst(rst), .start(start & ~sel), .abort(abort & ~sel), .mode(mode),
    .cell_out(cell3), .stim(stim3), .busy(busy3), .sample_valid(sv3), .sample_vec(svec3),
    .sample_exp(sexp3), .sample_got(sgot3), .err_count(err3), .first_fail(ff3),
    .done(done3), .pass(pass3), .mode_err(merr3));

  cell_truth_table_checker #(.N_INPUTS(4), .SETTLE_CYCLES(1)) u4 (
    .clk(clk), .rst(rst), .start(start & sel), .abort(abort & sel), .mode(mode),
    .cell_out(cell4), .stim(stim4), .busy(busy4), .sample_valid(sv4), .sample_vec(svec4),
    .sample_exp(sexp4), .sample_got(sgot4), .err_count(err4), .first_fail(ff4),
    .done(done4), .pass(pass4), .mode_err(merr4));

  // selected-instance view
  logic        sv_m, exp_m, done_m, pass_m, merr_m;
  logic [3:0]  vec_m, ff_m;
  logic [4:0]  err_m;
  assign sv_m   = sel ? sv4   : sv3;
  assign exp_m  = sel ? sexp4 : sexp3;
  assign done_m = sel ? done4 : done3;
  assign pass_m = sel ? pass4 : pass3;
  assign merr_m = sel ? merr4 : merr3;
  assign vec_m  = sel ? svec4 : {1'b0, svec3};
  assign ff_m   = sel ? ff4   : {1'b0, ff3};
  assign err_m  = sel ? err4  : {1'b0, err3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full sweep; inj>0 pulses a (to-be-ignored) start after that edge.
  task automatic sweep(input bit s, input logic [2:0] m, input int inj, input logic [15:0] exp_tbl,
                       input int exp_err, input int exp_ff, input bit exp_pass, input bit exp_merr,
                       input string tag);
    int nvec, per, nsamp, done_at;
    logic [15:0] eb;
    nvec = s ? 16 : 8;
    per  = s ? 2 : 3;
    nsamp = 0; done_at = -1; eb = '0;
    @(negedge clk); sel = s; mode = m; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      start = (k == inj);
      if (sv_m) begin
        chk($sformatf("%s vec%0d", tag, nsamp), 32'(vec_m), 32'(nsamp));
        chk($sformatf("%s t%0d", tag, nsamp), 32'(k), 32'((nsamp + 1) * per));
        eb[vec_m] = exp_m;
        nsamp++;
      end
      if (done_m) begin done_at = k; break; end
    end
    start = 1'b0;
    chk({tag, " nsamp"}, 32'(nsamp), 32'(nvec));
    chk({tag, " done_at"}, 32'(done_at), 32'(nvec * per));
    chk({tag, " exp"}, 32'(eb), 32'(exp_tbl));
    chk({tag, " err"}, 32'(err_m), 32'(exp_err));
    if (exp_err != 0) chk({tag, " ff"}, 32'(ff_m), 32'(exp_ff));
    chk({tag, " pass"}, 32'(pass_m), 32'(exp_pass));
    chk({tag, " merr"}, 32'(merr_m), 32'(exp_merr));
  endtask

  initial begin
    int nsamp;
    repeat (2) @(posedge clk);
    #1;
    chk("rst stim3", 32'(stim3), 0);
    chk("rst busy3", 32'(busy3), 0);
    chk("rst done3", 32'(done3), 0);
    chk("rst err4", 32'(err4), 0);
    chk("rst pass4", 32'(pass4), 0);
    @(negedge clk); rst = 1'b0;

    // clean NOR3, then stuck-at-1 at vec 5
    tbl3 = 8'h01;
    sweep(0, 3'd0, -1, 16'h0001, 0, 0, 1, 0, "nor");
    tbl3 = 8'h21;
    sweep(0, 3'd0, -1, 16'h0001, 1, 5, 0, 0, "fault");
    tbl3 = 8'h01;

    // mode sweep on the 4-input instance
    tbl4 = 16'h7FFF; sweep(1, 3'd1, -1, 16'h7FFF, 0, 0, 1, 0, "nand4");
    tbl4 = 16'h8000; sweep(1, 3'd2, -1, 16'h8000, 0, 0, 1, 0, "and4");
    tbl4 = 16'hFFFE; sweep(1, 3'd3, -1, 16'hFFFE, 0, 0, 1, 0, "or4");
    tbl4 = 16'h6996; sweep(1, 3'd4, -1, 16'h6996, 0, 0, 1, 0, "xor4");
    tbl4 = 16'h9669; sweep(1, 3'd5, -1, 16'h9669, 0, 0, 1, 0, "xnor4");

    // illegal mode against a NOR cell: only vec 0 disagrees with constant 0
    sweep(0, 3'd7, -1, 16'h0000, 1, 0, 0, 1, "illegal");

    // second start at vec 2 must be ignored
    sweep(0, 3'd0, 7, 16'h0001, 0, 0, 1, 0, "busy_start");

    // abort during SAMPLE of vec 3 (state SAMPLE after edge 11)
    @(negedge clk); sel = 1'b0; mode = 3'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    nsamp = 0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      if (sv3) nsamp++;
    end
    chk("abort pre stim", 32'(stim3), 3);
    chk("abort pre busy", 32'(busy3), 1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort nsamp", 32'(nsamp), 3);
    chk("abort sv", 32'(sv3), 0);
    chk("abort busy", 32'(busy3), 0);
    chk("abort stim", 32'(stim3), 0);
    chk("abort done", 32'(done3), 0);
    repeat (3) @(posedge clk);
    #1 chk("abort idle", 32'(busy3), 0);

    // async reset in SETTLE of vec 1
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rstmid pre stim", 32'(stim3), 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid busy", 32'(busy3), 0);
    chk("rstmid stim", 32'(stim3), 0);
    chk("rstmid sv", 32'(sv3), 0);
    chk("rstmid vec", 32'(svec3), 0);
    @(negedge clk); rst = 1'b0;
    sweep(0, 3'd0, -1, 16'h0001, 0, 0, 1, 0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cell_truth_table_checker.md
Name: cell_truth_table_checker

Overview:
Self-running, parametrised exhaustive checker for N-input single-output combinational standard cells such as NOR3_X4 and NAND4_X2. It walks every input vector and holds each one for a programmable settle time. It then samples the cell output against a selectable reference function and accumulates mismatches. It replaces the hand-written per-cell truth-table benches and sits between the bench top and the cell-under-test.

Parameters:
N_INPUTS, 3, number of cell inputs (1..8)
SETTLE_CYCLES, 2, cycles each vector is held before sampling (>=1)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request to begin a sweep; ignored while busy=1
abort  input  1  terminate a running sweep; no effect in IDLE or DONE
mode  input  3  reference function: 0 NOR, 1 NAND, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6/7 illegal
cell_out  input  1  output of the cell-under-test (ZN)
stim  output  N_INPUTS  drives the cell inputs; stim[N_INPUTS-1] = A1 (MSB), stim[0] = last input
busy  output  1  sweep in progress (SETTLE or SAMPLE)
sample_valid  output  1  one-cycle pulse per compared vector
sample_vec  output  N_INPUTS  vector just compared
sample_exp  output  1  expected value for sample_vec
sample_got  output  1  sampled cell_out
err_count  output  N_INPUTS+1  mismatches in the current or last sweep
first_fail  output  N_INPUTS  vector of the first mismatch (valid when err_count!=0)
done  output  1  sweep completed normally; held until the next accepted start
pass  output  1  done && err_count==0 && mode legal
mode_err  output  1  latched mode was 6 or 7

Behaviour:
- Reset (async, any state): state=IDLE; all outputs and internal counters 0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE or DONE + start=1 at an edge:
  - mode latches into mode_q.
  - mode_err = (mode>5).
  - vec=0, settle counter=SETTLE_CYCLES-1.
  - err_count, first_fail, done and pass clear.
  - Next state is SETTLE.
- An illegal mode still runs the sweep, with expected value fixed at 0. pass is forced to 0.
- stim = vec whenever the state is SETTLE or SAMPLE, and 0 otherwise. stim is registered.
- SETTLE: counter decrements each cycle. When counter==0 the next state is SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle): at the edge the block registers the following.
  - sample_valid=1 with sample_vec/exp/got.
  - On mismatch, err_count increments. When err_count was 0, first_fail=vec.
  - When vec == all-ones, the next state is DONE with done=1.
  - Otherwise vec increments, the counter reloads to SETTLE_CYCLES-1, and the next state is SETTLE.
- Expected value is computed over all N_INPUTS bits of vec:
  - NOR = ~|vec, NAND = ~&vec, AND = &vec, OR = |vec.
  - XOR = ^vec, XNOR = ~^vec.
- Timing: vector v is compared at the edge start_edge + (v+1)*(SETTLE_CYCLES+1). done rises at start_edge + 2^N_INPUTS*(SETTLE_CYCLES+1).
- err_count cannot overflow, since at most 2^N_INPUTS mismatches are possible.
- abort in SETTLE or SAMPLE: next state is IDLE and stim=0. A sample is not recorded on that edge, even if the state is SAMPLE; abort wins. done stays 0. err_count and first_fail keep their partial values.
- start together with abort in IDLE or DONE: start is honoured.
- start while busy: ignored and not queued.
- done, pass, err_count and first_fail hold in DONE until the next accepted start.
- sample_valid is 0 in every cycle except the one after each SAMPLE edge.

Test Plan:
- Clean NOR sweep: N=3, S=2, mode=0, with a behavioural NOR3 on cell_out.
  - 8 sample_valid pulses with vec 0..7.
  - exp = 1,0,0,0,0,0,0,0.
  - done at start+24, err_count=0, pass=1.
- Injected fault: the same bench with the cell output stuck-at-1 for vec=5 only. Required result: err_count=1, first_fail=3'b101, pass=0, done=1.
- Mode sweep: N=4, S=1, modes 1..5, each against a matching model. Each run gives 16 samples, err_count=0 and done at start+32. XOR expects exp=1 at vec=4'b0111.
- Illegal mode: mode=7 with a NOR model. Required result: mode_err=1, err_count=1 (only vec=0 mismatches), pass=0.
- Abort and reset mid-run:
  - abort during SAMPLE of vec=3 gives IDLE next cycle, stim=0, no sample for vec 3, done=0.
  - rst asserted asynchronously mid-SETTLE clears all outputs immediately.
  - A new start afterwards completes normally.
- Start while busy: a second start pulse at vec=2 is ignored. The sweep ends at the original done time.
